// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory sample arbiter: FSM states,
// ring-buffer placement and the field layout of an accelerometer sample.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  localparam logic [11:0] DEF_BUF_BASE  = 12'hF00;
  localparam int          DEF_BUF_DEPTH = 16;
  localparam int          DEF_MAX_WAIT  = 4;

  // Sample layout is x5|y5|z5, z in the low bits.
  localparam int ACL_FIELD_W = 5;
  localparam int ACL_Z_LSB   = 0;
  localparam int ACL_Y_LSB   = 5;
  localparam int ACL_X_LSB   = 10;

  function automatic logic [ACL_FIELD_W-1:0] acl_field(input logic [14:0] sample,
                                                       input int          lsb);
    return sample[lsb +: ACL_FIELD_W];
  endfunction

endpackage

// File: rtl/dmem_sample_arbiter_if.sv
// Bus bundle around the arbiter: CPU dmem request side, accelerometer
// sample handshake and the single RAM port.
interface dmem_sample_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int ACL_W  = 15
);
  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_stall;

  logic              acl_valid;
  logic [ACL_W-1:0]  acl_data;
  logic              acl_ready;

  logic              ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_data, acl_valid, acl_data,
    output cpu_stall, acl_ready, ram_wren, ram_addr, ram_data
  );

  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_data, acl_valid, acl_data,
    input  cpu_stall, acl_ready, ram_wren, ram_addr, ram_data
  );
endinterface

// File: rtl/dmem_sample_arbiter_ring_addr_gen.sv
// Ring-buffer write pointer and saturating count of samples written to RAM,
// both advanced by a single increment pulse.
module ring_addr_gen
  import dmem_arb_pkg::*;
#(
  parameter  int BUF_DEPTH = DEF_BUF_DEPTH,
  localparam int PTR_W     = $clog2(BUF_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [15:0]      sample_count
);

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr       <= '0;
      sample_count <= '0;
    end else if (inc) begin
      // Power-of-two depth: natural overflow is the ring wrap.
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (sample_count != 16'hFFFF) sample_count <= sample_count + 16'd1;
    end
  end

endmodule

// File: rtl/dmem_sample_arbiter.sv
// Shares the dmem RAM port between the CPU and accelerometer samples; samples
// are written to a RAM ring buffer, CPU has priority up to MAX_WAIT busy cycles.
module dmem_sample_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int                ADDR_W    = 12,
  parameter  int                DATA_W    = 32,
  parameter  int                ACL_W     = 15,
  parameter  logic [ADDR_W-1:0] BUF_BASE  = DEF_BUF_BASE,
  parameter  int                BUF_DEPTH = DEF_BUF_DEPTH,
  parameter  int                MAX_WAIT  = DEF_MAX_WAIT,
  localparam int                PTR_W     = $clog2(BUF_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  dmem_sample_arbiter_if.slave  bus,
  output logic [PTR_W-1:0]      wr_ptr,
  output logic [15:0]           sample_count,
  output logic                  overrun
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  arb_state_t        state;
  logic [ACL_W-1:0]  hold_data;
  logic [WAIT_W-1:0] wait_cnt;
  logic              grant;
  logic              capture;
  logic              wait_done;

  // Reset gating keeps a sample pending at reset from reaching RAM.
  assign grant     = reset && ((state == ST_PEND && !bus.cpu_req) || state == ST_FORCE);
  assign capture   = bus.acl_valid && bus.acl_ready;
  assign wait_done = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  assign bus.acl_ready = reset && (state == ST_IDLE || grant);
  assign bus.cpu_stall = reset && (state == ST_FORCE) && bus.cpu_req;

  // NOTE: every output gets a default before the branch, so no latch is inferred.
  always_comb begin
    bus.ram_wren = bus.cpu_req && bus.cpu_wren;
    bus.ram_addr = bus.cpu_addr;
    bus.ram_data = bus.cpu_data;
    if (grant) begin
      bus.ram_wren = 1'b1;
      bus.ram_addr = BUF_BASE + ADDR_W'(wr_ptr);
      bus.ram_data = {{(DATA_W - ACL_W){1'b0}}, hold_data};
    end
  end

  // NOTE: hold_data is a plain datapath register without reset; the FSM state
  // alone says whether it holds a valid sample.
  always_ff @(posedge clock) begin
    if (capture) hold_data <= bus.acl_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      // A sample arriving while the hold is full and not draining is dropped.
      overrun <= bus.acl_valid && !bus.acl_ready;
      unique case (state)
        ST_IDLE: begin
          if (capture) begin
            state    <= ST_PEND;
            wait_cnt <= '0;
          end
        end
        ST_PEND: begin
          if (!bus.cpu_req) begin
            state    <= capture ? ST_PEND : ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_done) state <= ST_FORCE;
          end
        end
        ST_FORCE: begin
          state    <= capture ? ST_PEND : ST_IDLE;
          wait_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ring_addr_gen #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_ring_addr_gen (
    .clock        (clock),
    .reset        (reset),
    .inc          (grant),
    .wr_ptr       (wr_ptr),
    .sample_count (sample_count)
  );

endmodule

// File: tb/tb_dmem_sample_arbiter.sv
// Scenario bench for dmem_sample_arbiter: RAM writes are scoreboarded against
// expected (addr, data) pairs queued when stimulus is driven.
module tb_dmem_sample_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int ACL_W     = 15;
  localparam int BUF_DEPTH = 16;
  localparam int MAX_WAIT  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  wr_ptr;
  logic [15:0] sample_count;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  wr_t         exp_q[$];
  wr_t         mon_exp;
  logic [31:0] ram_model [0:4095];

  always #5 clock = ~clock;

  dmem_sample_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACL_W(ACL_W)) bus ();

  dmem_sample_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ACL_W     (ACL_W),
    .BUF_BASE  (12'hF00),
    .BUF_DEPTH (BUF_DEPTH),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .wr_ptr       (wr_ptr),
    .sample_count (sample_count),
    .overrun      (overrun)
  );

  // Scoreboard: every RAM write must match the oldest queued expectation.
  always @(negedge clock) begin
    if (bus.ram_wren === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write_unexpected: got addr=%h data=%h, expected no write",
                 bus.ram_addr, bus.ram_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.ram_addr !== mon_exp.addr || bus.ram_data !== mon_exp.data) begin
          errors++;
          $display("FAIL ram_write: got addr=%h data=%h, expected addr=%h data=%h",
                   bus.ram_addr, bus.ram_data, mon_exp.addr, mon_exp.data);
        end
      end
      ram_model[bus.ram_addr] = bus.ram_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    settle();
    checks++;
    if (wr_ptr !== 4'd0 || sample_count !== 16'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got wr_ptr=%0d count=%0d overrun=%b, expected 0 0 0",
               wr_ptr, sample_count, overrun);
    end
    checks++;
    if (bus.acl_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_acl_ready: got %b expected 1", bus.acl_ready);
    end
    // Put a sample into PEND, then reset while it would otherwise be granted.
    tick();
    bus.acl_valid = 1'b1;
    bus.acl_data  = 15'h7FFF;
    bus.cpu_req   = 1'b1;
    tick();
    bus.acl_valid = 1'b0;
    settle();
    checks++;
    if (bus.acl_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_pend_entered: got acl_ready=%b expected 0", bus.acl_ready);
    end
    tick();
    reset       = 1'b0;
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (bus.ram_wren !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_write[%0d]: got ram_wren=%b expected 0", i, bus.ram_wren);
      end
      tick();
    end
    reset = 1'b1;
    settle();
    checks++;
    if (bus.acl_ready !== 1'b1 || wr_ptr !== 4'd0 || sample_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_pend: got acl_ready=%b wr_ptr=%0d count=%0d, expected 1 0 0",
               bus.acl_ready, wr_ptr, sample_count);
    end
  endtask

  task automatic test_idle_cpu();
    tick();
    bus.acl_valid = 1'b1;
    bus.acl_data  = 15'h1ABC;
    bus.cpu_req   = 1'b0;
    exp_q.push_back('{addr: 12'hF00, data: 32'h0000_1ABC});
    settle();
    checks++;
    if (bus.acl_ready !== 1'b1 || bus.ram_wren !== 1'b0) begin
      errors++;
      $display("FAIL idle_capture: got acl_ready=%b ram_wren=%b, expected 1 0",
               bus.acl_ready, bus.ram_wren);
    end
    tick();
    bus.acl_valid = 1'b0;
    settle();
    checks++;
    if (bus.ram_wren !== 1'b1 || bus.ram_addr !== 12'hF00 || bus.ram_data !== 32'h1ABC) begin
      errors++;
      $display("FAIL idle_latency: got wren=%b addr=%h data=%h, expected 1 f00 00001abc",
               bus.ram_wren, bus.ram_addr, bus.ram_data);
    end
    tick();
    settle();
    checks++;
    if (wr_ptr !== 4'd1 || sample_count !== 16'd1) begin
      errors++;
      $display("FAIL idle_ptr: got wr_ptr=%0d count=%0d, expected 1 1", wr_ptr, sample_count);
    end
  endtask

  task automatic test_busy_cpu();
    tick();
    bus.acl_valid = 1'b1;
    bus.acl_data  = 15'h0123;
    bus.cpu_req   = 1'b1;
    bus.cpu_wren  = 1'b0;
    bus.cpu_addr  = 12'h040;
    exp_q.push_back('{addr: 12'hF01, data: 32'h0000_0123});
    tick();
    bus.acl_valid = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      settle();
      checks++;
      if (bus.cpu_stall !== 1'b0 || bus.ram_wren !== 1'b0) begin
        errors++;
        $display("FAIL busy_served[%0d]: got stall=%b wren=%b, expected 0 0",
                 i, bus.cpu_stall, bus.ram_wren);
      end
      tick();
    end
    settle();
    checks++;
    if (bus.cpu_stall !== 1'b1 || bus.ram_wren !== 1'b1 || bus.ram_addr !== 12'hF01) begin
      errors++;
      $display("FAIL busy_force: got stall=%b wren=%b addr=%h, expected 1 1 f01",
               bus.cpu_stall, bus.ram_wren, bus.ram_addr);
    end
    tick();
    settle();
    checks++;
    if (bus.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL busy_stall_once: got stall=%b expected 0", bus.cpu_stall);
    end
    tick();
    bus.cpu_req = 1'b0;
    settle();
    checks++;
    if (wr_ptr !== 4'd2 || sample_count !== 16'd2) begin
      errors++;
      $display("FAIL busy_ptr: got wr_ptr=%0d count=%0d, expected 2 2", wr_ptr, sample_count);
    end
  endtask

  task automatic test_overrun();
    tick();
    bus.acl_valid = 1'b1;
    bus.acl_data  = 15'h0AAA;
    bus.cpu_req   = 1'b1;
    bus.cpu_wren  = 1'b0;
    exp_q.push_back('{addr: 12'hF02, data: 32'h0000_0AAA});
    tick();
    bus.acl_data = 15'h0555;
    settle();
    checks++;
    if (bus.acl_ready !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_full: got acl_ready=%b overrun=%b, expected 0 0",
               bus.acl_ready, overrun);
    end
    tick();
    bus.acl_valid = 1'b0;
    settle();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got %b expected 1", overrun);
    end
    tick();
    settle();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_single: got %b expected 0", overrun);
    end
    tick();
    bus.cpu_req = 1'b0;
    tick();
    tick();
    settle();
    checks++;
    if (wr_ptr !== 4'd3 || sample_count !== 16'd3) begin
      errors++;
      $display("FAIL overrun_ptr: got wr_ptr=%0d count=%0d, expected 3 3", wr_ptr, sample_count);
    end
    checks++;
    if (ram_model[12'hF02] !== 32'h0AAA || ram_model[12'hF03] !== 32'h0) begin
      errors++;
      $display("FAIL overrun_ram: got f02=%h f03=%h, expected 00000aaa 00000000",
               ram_model[12'hF02], ram_model[12'hF03]);
    end
  endtask

  task automatic test_passthrough();
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_wren = 1'b1;
    bus.cpu_addr = 12'h010;
    bus.cpu_data = 32'hDEADBEEF;
    exp_q.push_back('{addr: 12'h010, data: 32'hDEADBEEF});
    settle();
    checks++;
    if (bus.ram_wren !== 1'b1 || bus.ram_addr !== 12'h010 || bus.ram_data !== 32'hDEADBEEF ||
        bus.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL passthrough: got wren=%b addr=%h data=%h stall=%b, expected 1 010 deadbeef 0",
               bus.ram_wren, bus.ram_addr, bus.ram_data, bus.cpu_stall);
    end
    tick();
    bus.cpu_req  = 1'b0;
    bus.cpu_wren = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    logic [14:0] sample;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    settle();
    checks++;
    if (wr_ptr !== 4'd0 || sample_count !== 16'd0) begin
      errors++;
      $display("FAIL wrap_reset: got wr_ptr=%0d count=%0d, expected 0 0", wr_ptr, sample_count);
    end
    tick();
    bus.cpu_req   = 1'b0;
    bus.acl_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sample       = 15'(i * 16'h0111 + 1);
      bus.acl_data = sample;
      exp_q.push_back('{addr: 12'hF00 + 12'(i % BUF_DEPTH), data: {17'b0, sample}});
      settle();
      checks++;
      if (bus.acl_ready !== 1'b1) begin
        errors++;
        $display("FAIL wrap_ready[%0d]: got %b expected 1", i, bus.acl_ready);
      end
      tick();
    end
    bus.acl_valid = 1'b0;
    tick();
    settle();
    checks++;
    if (wr_ptr !== 4'd1 || sample_count !== 16'd17 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ptr: got wr_ptr=%0d count=%0d overrun=%b, expected 1 17 0",
               wr_ptr, sample_count, overrun);
    end
    checks++;
    if (ram_model[12'hF00] !== 32'h1111 || ram_model[12'hF0F] !== 32'h1000) begin
      errors++;
      $display("FAIL wrap_ram: got f00=%h f0f=%h, expected 00001111 00001000",
               ram_model[12'hF00], ram_model[12'hF0F]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram_model[i] = 32'h0;
    bus.cpu_req   = 1'b0;
    bus.cpu_wren  = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_data  = '0;
    bus.acl_valid = 1'b0;
    bus.acl_data  = '0;

    test_reset();
    test_idle_cpu();
    test_busy_cpu();
    test_overrun();
    test_passthrough();
    test_back_to_back_wrap();

    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
